// File: rtl/otter_intc.sv
// -----------------------------------------------------------------------------
// otter_intc -- multi-source interrupt controller for the OTTER MCU.
//
// Rising edges on the peripheral lines are latched as pending. The lowest
// numbered source that is both pending and enabled wins arbitration. The
// controller raises `intr` until the MCU reports `int_taken`. It then holds
// the winning ID in CAUSE until software writes that ID to ACK.
//
// Ports:
//   clk, rst_n   clock (rising edge), synchronous active-low reset
//   irq_src      peripheral interrupt lines (level in, edge detected)
//   int_taken    one-cycle pulse when the MCU enters its interrupt state
//   intr         interrupt request to the MCU
//   iobus_addr   MMIO address
//   iobus_out    MMIO write data
//   iobus_wr     MMIO write strobe
//   rd_data      register read data, zero outside the window
//   rd_hit       iobus_addr lies inside the 4-word register window
//
// Register window (byte offsets from BASE_ADDR):
//   0x0 PENDING (RO), 0x4 ENABLE (RW), 0x8 CAUSE (RO: bit31 valid,
//   bits[4:0] ID), 0xC ACK (WO: write the source ID to clear it, reads 0)
// -----------------------------------------------------------------------------
module otter_intc #(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             int_taken,
  output logic             intr,
  input  logic [31:0]      iobus_addr,
  input  logic [31:0]      iobus_out,
  input  logic             iobus_wr,
  output logic [31:0]      rd_data,
  output logic             rd_hit
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_ENABLE  = 2'd1,
    REG_CAUSE   = 2'd2,
    REG_ACK     = 2'd3
  } reg_sel_t;

  state_t           state;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] enable;
  logic             cause_valid;
  logic [4:0]       cause_id;

  // ---------------------------------------------------------------------------
  // Address decode. Subtracting the base keeps the decode correct for any
  // word-aligned base, even one that is not 16-byte aligned.
  // ---------------------------------------------------------------------------
  logic [31:0] offset;
  reg_sel_t    reg_sel;
  logic        en_wr;
  logic        ack_wr;
  logic [4:0]  ack_id;

  assign offset  = iobus_addr - BASE_ADDR;
  assign rd_hit  = (offset[31:4] == 28'd0);
  assign reg_sel = reg_sel_t'(offset[3:2]);
  assign en_wr   = iobus_wr && rd_hit && (reg_sel == REG_ENABLE);
  assign ack_wr  = iobus_wr && rd_hit && (reg_sel == REG_ACK);
  assign ack_id  = iobus_out[4:0];

  // Only the low bits of the write data and the word part of the offset
  // matter. The remaining bits are consumed here on purpose.
  logic unused_ok;
  assign unused_ok = ^{iobus_out, offset[1:0]};

  // ---------------------------------------------------------------------------
  // Edge detect, acknowledge mask and arbitration.
  // ---------------------------------------------------------------------------
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] req_vec;
  logic [4:0]       winner;

  assign rise    = irq_src & ~prev;
  assign req_vec = pending & enable;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path through the block can leave it holding a value
  // (which would infer a latch).
  always_comb begin
    ack_clr = '0;
    // IDs at or above N_SRC match no bit, so they are ignored naturally.
    for (int i = 0; i < N_SRC; i++) begin
      ack_clr[i] = ack_wr && (ack_id == 5'(i));
    end
  end

  // Scan from the top down so that the lowest set index is assigned last.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_vec[i]) winner = 5'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // State, pending/enable registers and CAUSE.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      prev        <= '1;  // lines held high through reset do not count as edges
      pending     <= '0;
      enable      <= '0;
      cause_valid <= 1'b0;
      cause_id    <= '0;
    end else begin
      prev    <= irq_src;
      // A new edge overrides a simultaneous acknowledge of the same bit.
      pending <= (pending & ~ack_clr) | rise;
      if (en_wr) enable <= iobus_out[N_SRC-1:0];

      unique case (state)
        IDLE: begin
          if (|req_vec) state <= REQ;
        end
        REQ: begin
          if (int_taken) begin
            cause_valid <= 1'b1;
            cause_id    <= winner;
            state       <= SERVICE;
          end else if (req_vec == '0) begin
            state <= IDLE;
          end
        end
        SERVICE: begin
          if (ack_wr && (ack_id == cause_id)) begin
            cause_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign intr = (state == REQ);

  // ---------------------------------------------------------------------------
  // Read mux. Reads have no side effects.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    if (rd_hit) begin
      unique case (reg_sel)
        REG_PENDING: rd_data = 32'(pending);
        REG_ENABLE:  rd_data = 32'(enable);
        REG_CAUSE:   rd_data = {cause_valid, 26'd0, cause_id};
        default:     rd_data = '0;
      endcase
    end
  end

endmodule
